// File: rtl/pe_issue_ctrl.sv
// Instruction sequencer for parallel_pe: streams neuron/weight SRAM lines per beat,
// aligns first/last flags with read data, and tracks outstanding PE results.
module pe_issue_ctrl #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 512,
  parameter int LEN_W   = 8,
  parameter int MAX_OUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inst_valid,
  output logic              inst_ready,
  input  logic [LEN_W-1:0]  inst_len,
  input  logic [ADDR_W-1:0] inst_nbase,
  input  logic [ADDR_W-1:0] inst_wbase,
  output logic              nram_ren,
  output logic [ADDR_W-1:0] nram_raddr,
  input  logic [DATA_W-1:0] nram_rdata,
  output logic              wram_ren,
  output logic [ADDR_W-1:0] wram_raddr,
  input  logic [DATA_W-1:0] wram_rdata,
  output logic [DATA_W-1:0] pe_neuron,
  output logic [DATA_W-1:0] pe_weight,
  output logic [1:0]        pe_ctl,
  output logic              pe_vld_i,
  input  logic              pe_vld_o,
  output logic              busy,
  output logic              done,
  output logic              err_unexp
);
  localparam int CNT_W = $clog2(MAX_OUT + 1);

  typedef enum logic {IDLE, ISSUE} state_e;

  state_e              state_q, state_d;
  logic [LEN_W-1:0]    idx_q, idx_d, len_q, len_d;
  logic [ADDR_W-1:0]   naddr_q, naddr_d, waddr_q, waddr_d;
  logic [CNT_W-1:0]    out_q, out_d;
  logic                err_q, err_d;
  logic                pe_vld_q, busy_q;
  logic [1:0]          pe_ctl_q;
  logic                issue, first, last, room, accept, acc_run;

  assign issue   = (state_q == ISSUE);
  assign first   = (idx_q == '0);
  assign last    = issue && (idx_q == len_q - LEN_W'(1));
  assign room    = (out_q < CNT_W'(MAX_OUT));
  // Ready is held low while reset is asserted, independent of register state.
  assign inst_ready = rst_n && (!issue || last) && room;
  assign accept  = inst_valid && inst_ready;
  assign acc_run = accept && (inst_len != '0);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    naddr_d = naddr_q;
    waddr_d = waddr_q;
    if (issue) begin
      idx_d   = idx_q + LEN_W'(1);
      naddr_d = naddr_q + ADDR_W'(1);
      waddr_d = waddr_q + ADDR_W'(1);
      if (last) state_d = IDLE;
    end
    // A reload on the last beat keeps the beat stream contiguous.
    if (acc_run) begin
      state_d = ISSUE;
      idx_d   = '0;
      len_d   = inst_len;
      naddr_d = inst_nbase;
      waddr_d = inst_wbase;
    end
  end

  always_comb begin
    out_d = out_q;
    err_d = err_q;
    case ({acc_run, pe_vld_o})
      2'b10: out_d = out_q + CNT_W'(1);
      2'b01: begin
        if (out_q == '0) err_d = 1'b1;
        else             out_d = out_q - CNT_W'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      len_q    <= '0;
      naddr_q  <= '0;
      waddr_q  <= '0;
      out_q    <= '0;
      err_q    <= 1'b0;
      pe_vld_q <= 1'b0;
      pe_ctl_q <= 2'b00;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      len_q    <= len_d;
      naddr_q  <= naddr_d;
      waddr_q  <= waddr_d;
      out_q    <= out_d;
      err_q    <= err_d;
      pe_vld_q <= issue;
      pe_ctl_q <= issue ? {last, first} : 2'b00;
      busy_q   <= busy;
    end
  end

  assign nram_ren   = issue;
  assign wram_ren   = issue;
  assign nram_raddr = naddr_q;
  assign wram_raddr = waddr_q;
  assign pe_neuron  = nram_rdata;
  assign pe_weight  = wram_rdata;
  assign pe_vld_i   = pe_vld_q;
  assign pe_ctl     = pe_ctl_q;
  assign busy       = issue || pe_vld_q || (out_q != '0);
  assign done       = busy_q && !busy;
  assign err_unexp  = err_q;

endmodule
